// File: rtl/mac_8bit_feeder.sv
// mac_8bit_feeder: takes a job from fabric logic, streams its operand/coefficient
// pairs into one MAC_8BIT accumulator, then returns the selected result over a
// valid/ready handshake. All arithmetic happens inside the MAC.
module mac_8bit_feeder #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 MAC_ACC_CLK,
   input  logic                 acc_ff_rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] cfg_len,
   input  logic [5:0]           cfg_out_sel,
   input  logic                 cfg_rnd,
   input  logic                 cfg_sat,
   input  logic                 cfg_tc,
   output logic                 busy,
   output logic                 err,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [7:0]           s_oper,
   input  logic [7:0]           s_coef,
   output logic                 r_valid,
   input  logic                 r_ready,
   output logic [7:0]           r_data,
   output logic                 EFPGA_MATHB_CLK_EN,
   output logic [7:0]           MAC_OPER_DATA,
   output logic [7:0]           MAC_COEF_DATA,
   output logic                 MAC_ACC_CLEAR,
   output logic                 MAC_ACC_RND,
   output logic                 MAC_ACC_SAT,
   output logic [5:0]           MAC_OUT_SEL,
   output logic                 MAC_TC,
   input  logic [7:0]           MAC_OUT
);

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned SEL_W   = 6;
   localparam int unsigned MAX_SEL = 16;

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, CAPT, RESULT} state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] remaining, remaining_nxt;
   logic                 first, first_nxt;
   logic                 rnd_cfg, rnd_cfg_nxt;
   logic                 err_nxt, clk_en_nxt, clear_nxt, rnd_nxt, sat_nxt, tc_nxt;
   logic [DATA_W-1:0]    oper_nxt, coef_nxt, r_data_nxt;
   logic [SEL_W-1:0]     sel_nxt;
   logic                 handshake;

   // A pair moves only while the feeder itself advertises ready
   assign handshake = s_valid & s_ready;

   // State, job context and every output are registered here
   always_ff @(posedge MAC_ACC_CLK or posedge acc_ff_rst) begin
      if (acc_ff_rst) begin
         state              <= IDLE;
         remaining          <= '0;
         first              <= 1'b0;
         rnd_cfg            <= 1'b0;
         busy               <= 1'b0;
         err                <= 1'b0;
         s_ready            <= 1'b0;
         r_valid            <= 1'b0;
         r_data             <= '0;
         EFPGA_MATHB_CLK_EN <= 1'b0;
         MAC_OPER_DATA      <= '0;
         MAC_COEF_DATA      <= '0;
         MAC_ACC_CLEAR      <= 1'b0;
         MAC_ACC_RND        <= 1'b0;
         MAC_ACC_SAT        <= 1'b0;
         MAC_OUT_SEL        <= '0;
         MAC_TC             <= 1'b0;
      end else begin
         state              <= state_nxt;
         remaining          <= remaining_nxt;
         first              <= first_nxt;
         rnd_cfg            <= rnd_cfg_nxt;
         busy               <= (state_nxt != IDLE);
         err                <= err_nxt;
         s_ready            <= (state_nxt == RUN);
         r_valid            <= (state_nxt == RESULT);
         r_data             <= r_data_nxt;
         EFPGA_MATHB_CLK_EN <= clk_en_nxt;
         MAC_OPER_DATA      <= oper_nxt;
         MAC_COEF_DATA      <= coef_nxt;
         MAC_ACC_CLEAR      <= clear_nxt;
         MAC_ACC_RND        <= rnd_nxt;
         MAC_ACC_SAT        <= sat_nxt;
         MAC_OUT_SEL        <= sel_nxt;
         MAC_TC             <= tc_nxt;
      end
   end

   // Next-state and next-output logic; MAC strobes default low, data and config hold
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      first_nxt     = first;
      rnd_cfg_nxt   = rnd_cfg;
      err_nxt       = 1'b0;
      clk_en_nxt    = 1'b0;
      clear_nxt     = 1'b0;
      rnd_nxt       = 1'b0;
      oper_nxt      = MAC_OPER_DATA;
      coef_nxt      = MAC_COEF_DATA;
      sat_nxt       = MAC_ACC_SAT;
      sel_nxt       = MAC_OUT_SEL;
      tc_nxt        = MAC_TC;
      r_data_nxt    = r_data;

      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_out_sel <= SEL_W'(MAX_SEL)) begin
                  sel_nxt       = cfg_out_sel;
                  sat_nxt       = cfg_sat;
                  tc_nxt        = cfg_tc;
                  rnd_cfg_nxt   = cfg_rnd;
                  remaining_nxt = cfg_len;
                  first_nxt     = 1'b1;
                  state_nxt     = RUN;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            // abort outranks a simultaneous handshake
            if (abort) begin
               state_nxt = IDLE;
            end else if (handshake) begin
               oper_nxt   = s_oper;
               coef_nxt   = s_coef;
               clk_en_nxt = 1'b1;
               clear_nxt  = first & ~rnd_cfg;
               rnd_nxt    = first & rnd_cfg;
               first_nxt  = 1'b0;
               if (remaining == '0) begin
                  state_nxt = FLUSH;
               end else begin
                  remaining_nxt = remaining - CNT_WIDTH'(1);
               end
            end
         end
         FLUSH: begin
            // the last pair is on the MAC inputs with CLK_EN high this cycle
            state_nxt = abort ? IDLE : CAPT;
         end
         CAPT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               r_data_nxt = MAC_OUT;
               state_nxt  = RESULT;
            end
         end
         RESULT: begin
            if (abort || r_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_8bit_feeder.sv
// tb_mac_8bit_feeder: drives jobs into mac_8bit_feeder, emulates the MAC_8BIT
// accumulator behind it, and checks MAC port traffic and results against a
// job-level arithmetic model.
module tb_mac_8bit_feeder;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] cfg_len = '0;
   logic [5:0]       cfg_out_sel = '0;
   logic             cfg_rnd = 1'b0;
   logic             cfg_sat = 1'b0;
   logic             cfg_tc = 1'b0;
   logic             busy, err;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [7:0]       s_oper = '0;
   logic [7:0]       s_coef = '0;
   logic             r_valid;
   logic             r_ready = 1'b0;
   logic [7:0]       r_data;
   logic             clk_en, clear, rnd, sat, tc;
   logic [7:0]       oper, coef, mac_out;
   logic [5:0]       sel;
   logic [63:0]      outs_c;

   typedef struct {
      logic [7:0] oper;
      logic [7:0] coef;
      bit         first;
   } pair_t;

   pair_t      acc_q[$];
   logic [7:0] p_oper[0:255];
   logic [7:0] p_coef[0:255];
   int         j_sel = 0;
   bit         j_rnd = 1'b0, j_sat = 1'b0, j_tc = 1'b0;
   logic [7:0] exp_res = '0;
   bit         res_expected = 1'b0;
   int         n_cmp = 0;
   int         n_fail = 0;
   longint     acc = 64'sd23130;

   mac_8bit_feeder #(.CNT_WIDTH(CNT_W)) dut (
      .MAC_ACC_CLK(clk), .acc_ff_rst(rst), .start(start), .abort(abort),
      .cfg_len(cfg_len), .cfg_out_sel(cfg_out_sel), .cfg_rnd(cfg_rnd),
      .cfg_sat(cfg_sat), .cfg_tc(cfg_tc), .busy(busy), .err(err),
      .s_valid(s_valid), .s_ready(s_ready), .s_oper(s_oper), .s_coef(s_coef),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .EFPGA_MATHB_CLK_EN(clk_en), .MAC_OPER_DATA(oper), .MAC_COEF_DATA(coef),
      .MAC_ACC_CLEAR(clear), .MAC_ACC_RND(rnd), .MAC_ACC_SAT(sat),
      .MAC_OUT_SEL(sel), .MAC_TC(tc), .MAC_OUT(mac_out)
   );

   always #5 clk = ~clk;

   assign outs_c = 64'({busy, err, s_ready, r_valid, r_data, clk_en, oper, coef,
                        clear, rnd, sat, sel, tc});

   function automatic longint prod(input logic [7:0] a, input logic [7:0] b, input bit tc_i);
      longint x, y;
      x = tc_i ? longint'({{56{a[7]}}, a}) : longint'({56'b0, a});
      y = tc_i ? longint'({{56{b[7]}}, b}) : longint'({56'b0, b});
      return x * y;
   endfunction

   function automatic longint rc(input int s);
      return (s == 0) ? 64'sd0 : (64'sd1 <<< (s - 1));
   endfunction

   // Bit select with optional clamp to the signed/unsigned 8-bit range
   function automatic logic [7:0] sel_out(input longint a, input int s, input bit sat_i, input bit tc_i);
      longint      v;
      logic [63:0] u;
      v = a >>> s;
      if (sat_i) begin
         if (tc_i) begin
            if (v > 127) v = 127;
            else if (v < -128) v = -128;
         end else begin
            if (v > 255) v = 255;
            else if (v < 0) v = 0;
         end
      end
      u = v;
      return u[7:0];
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endfunction

   // MAC_8BIT stand-in: accumulator is deliberately not reset
   always @(posedge clk) begin
      if (clk_en) acc <= (clear ? 64'sd0 : (rnd ? rc(int'(sel)) : acc)) + prod(oper, coef, tc);
   end
   assign mac_out = sel_out(acc, int'(sel), sat, tc);

   // Per-cycle check of MAC port traffic, held job config and result
   always @(negedge clk) begin
      pair_t p;
      if (!rst) begin
         if (clk_en) begin
            if (acc_q.size() == 0) chk("clk_en_unexpected", 64'(clk_en), 64'd0);
            else begin
               p = acc_q.pop_front();
               chk("mac_oper", 64'(oper), 64'(p.oper));
               chk("mac_coef", 64'(coef), 64'(p.coef));
               chk("mac_clear", 64'(clear), 64'(p.first && !j_rnd));
               chk("mac_rnd", 64'(rnd), 64'(p.first && j_rnd));
            end
         end else begin
            chk("ctrl_quiet", 64'({clear, rnd}), 64'd0);
         end
         if (busy) begin
            chk("out_sel_held", 64'(sel), 64'(j_sel));
            chk("sat_held", 64'(sat), 64'(j_sat));
            chk("tc_held", 64'(tc), 64'(j_tc));
         end
         if (r_valid) begin
            if (res_expected) chk("r_data", 64'(r_data), 64'(exp_res));
            else chk("r_valid_unexpected", 64'(r_valid), 64'd0);
         end
      end
   end

   task automatic setp(input int i, input logic [7:0] o, input logic [7:0] c);
      p_oper[i] = o;
      p_coef[i] = c;
   endtask

   task automatic run_job(input int n, input int osel, input bit rnd_i, input bit sat_i,
                          input bit tc_i, input int gap, input int rdel, input bit poke,
                          input bit restart, input int want);
      longint     sum;
      int         t;
      logic [7:0] got;
      sum = rnd_i ? rc(osel) : 64'sd0;
      for (int i = 0; i < n; i++) sum += prod(p_oper[i], p_coef[i], tc_i);
      j_sel = osel; j_rnd = rnd_i; j_sat = sat_i; j_tc = tc_i;
      exp_res = sel_out(sum, osel, sat_i, tc_i);
      res_expected = 1'b1;
      cfg_len = CNT_W'(n - 1); cfg_out_sel = 6'(osel);
      cfg_rnd = rnd_i; cfg_sat = sat_i; cfg_tc = tc_i;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_out_sel = 6'($urandom_range(0, 63));
      cfg_rnd = ~rnd_i; cfg_sat = ~sat_i; cfg_tc = ~tc_i;
      chk("busy_on_start", 64'(busy), 64'd1);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && gap > 0) begin
            s_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
               if (poke && g == 0) begin start = 1'b1; cfg_out_sel = 6'd20; end
               @(negedge clk);
               if (poke && g == 0) begin start = 1'b0; chk("err_while_busy", 64'(err), 64'd0); end
            end
         end
         s_valid = 1'b1; s_oper = p_oper[i]; s_coef = p_coef[i];
         t = 0;
         while (!s_ready && t < 20) begin @(negedge clk); t++; end
         if (!s_ready) begin
            chk("s_ready_timeout", 64'(s_ready), 64'd1);
            s_valid = 1'b0;
            res_expected = 1'b0;
            return;
         end
         acc_q.push_back('{oper: p_oper[i], coef: p_coef[i], first: (i == 0)});
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("s_ready_after_last", 64'(s_ready), 64'd0);
      t = 1;
      while (!r_valid && t < 10) begin @(negedge clk); t++; end
      chk("result_latency", 64'(t), 64'd3);
      got = r_data;
      repeat (rdel) @(negedge clk);
      r_ready = 1'b1;
      if (restart) begin start = 1'b1; cfg_out_sel = 6'd0; end
      @(negedge clk);
      r_ready = 1'b0; start = 1'b0;
      res_expected = 1'b0;
      chk("r_valid_drop", 64'(r_valid), 64'd0);
      chk("idle_after_result", 64'(busy), 64'd0);
      if (want >= 0) chk("directed_result", 64'(got), 64'(want));
   endtask

   // Bounded run time guard
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n, gap;
      repeat (2) @(negedge clk);
      chk("reset_outputs", outs_c, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // unsigned accumulate
      setp(0, 8'd2, 8'd3); setp(1, 8'd4, 8'd5); setp(2, 8'd1, 8'd1);
      run_job(3, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'h1B);
      // signed accumulate
      setp(0, 8'hFD, 8'h04); setp(1, 8'h02, 8'h02);
      run_job(2, 0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 8'hF8);
      // saturation on and off
      setp(0, 8'h7F, 8'h7F);
      run_job(1, 0, 1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 8'h7F);
      run_job(1, 0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 8'h01);
      // rounding on and off
      setp(0, 8'd3, 8'd5);
      run_job(1, 4, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'h01);
      run_job(1, 4, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'h00);

      // rejected start: err pulse, config untouched
      cfg_out_sel = 6'd17; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 64'(err), 64'd1);
      chk("err_not_busy", 64'(busy), 64'd0);
      chk("err_sel_held", 64'(sel), 64'(j_sel));
      @(negedge clk);
      chk("err_one_cycle", 64'(err), 64'd0);

      // gaps between pairs, held result, start while busy and in RESULT
      setp(0, 8'd2, 8'd3); setp(1, 8'd4, 8'd5); setp(2, 8'd1, 8'd1);
      run_job(3, 0, 1'b0, 1'b0, 1'b0, 3, 5, 1'b1, 1'b1, 8'h1B);

      // abort after one of three pairs, with a pair offered on the abort edge
      j_sel = 2; j_rnd = 1'b0; j_sat = 1'b0; j_tc = 1'b0; res_expected = 1'b0;
      cfg_len = CNT_W'(2); cfg_out_sel = 6'd2; cfg_rnd = 1'b0; cfg_sat = 1'b0; cfg_tc = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("run_ready", 64'(s_ready), 64'd1);
      s_valid = 1'b1; s_oper = 8'd9; s_coef = 8'd9;
      acc_q.push_back('{oper: 8'd9, coef: 8'd9, first: 1'b1});
      @(negedge clk);
      s_oper = 8'd8; s_coef = 8'd8; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; s_valid = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_s_ready", 64'(s_ready), 64'd0);
      chk("abort_clk_en", 64'(clk_en), 64'd0);
      repeat (4) @(negedge clk);

      // reset in the middle of a job, then a clean job
      j_sel = 0;
      cfg_len = CNT_W'(2); cfg_out_sel = 6'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      s_valid = 1'b1; s_oper = 8'd7; s_coef = 8'd7;
      acc_q.push_back('{oper: 8'd7, coef: 8'd7, first: 1'b1});
      @(negedge clk);
      s_oper = 8'd6; s_coef = 8'd6;
      acc_q.push_back('{oper: 8'd6, coef: 8'd6, first: 1'b0});
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset_mid_run", outs_c, 64'd0);
      s_valid = 1'b0;
      acc_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_job(3, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'h1B);

      // randomized jobs
      for (int k = 0; k < 40; k++) begin
         n = ($urandom_range(0, 9) == 0) ? 24 : int'($urandom_range(1, 6));
         for (int i = 0; i < n; i++) setp(i, 8'($urandom), 8'($urandom));
         gap = int'($urandom_range(0, 2));
         run_job(n, int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gap,
                 int'($urandom_range(0, 3)),
                 (gap > 0) && (n > 1) && ($urandom_range(0, 1) == 1),
                 1'($urandom_range(0, 1)), -1);
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_8bit_feeder.md
Name: mac_8bit_feeder

Overview:
- Initiator-side sequencer that drives the input port set of one 8-bit eFPGA math-block MAC accumulator (MAC_8BIT) and reads its MAC_OUT result.
- Accepts a job from fabric logic, then streams N operand/coefficient pairs into the MAC. The first pair clears or round-seeds the accumulator.
- Captures the final 8-bit result and returns it over a valid/ready handshake.

Parameters:
- CNT_WIDTH, 8, width of cfg_len; a job carries cfg_len+1 pairs (1..2^CNT_WIDTH).

Ports:
- MAC_ACC_CLK  in  1  block clock; shared with the MAC.
- acc_ff_rst  in  1  asynchronous reset, active-high.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  drop the current job; return to IDLE with no result.
- cfg_len  in  CNT_WIDTH  number of pairs minus 1.
- cfg_out_sel  in  6  result bit offset, 0..16.
- cfg_rnd  in  1  seed the accumulator with the round constant instead of clearing it.
- cfg_sat  in  1  enable saturation.
- cfg_tc  in  1  two's-complement operands.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse when start is rejected.
- s_valid  in  1  pair valid.
- s_ready  out  1  pair ready.
- s_oper  in  8  operand.
- s_coef  in  8  coefficient.
- r_valid  out  1  result valid.
- r_ready  in  1  result accepted.
- r_data  out  8  result.
- EFPGA_MATHB_CLK_EN  out  1  MAC accumulate enable.
- MAC_OPER_DATA  out  8  to the MAC.
- MAC_COEF_DATA  out  8  to the MAC.
- MAC_ACC_CLEAR  out  1  to the MAC.
- MAC_ACC_RND  out  1  to the MAC.
- MAC_ACC_SAT  out  1  to the MAC.
- MAC_OUT_SEL  out  6  to the MAC.
- MAC_TC  out  1  to the MAC.
- MAC_OUT  in  8  MAC result.

Behaviour:
- Clock and reset:
  - One clock, MAC_ACC_CLK.
  - acc_ff_rst is asynchronous, active-high.
  - All outputs come from flops. Reset value is 0 for every output.
  - State resets to IDLE, the pair counter to 0, and r_data to 0.
- States: IDLE, RUN, FLUSH, CAPT, RESULT.
- IDLE:
  - On start=1 with cfg_out_sel<=16:
    - Register MAC_OUT_SEL, MAC_ACC_SAT and MAC_TC from the cfg_* inputs.
    - Load remaining=cfg_len, set first=1, go to RUN.
  - On start=1 with cfg_out_sel>16: pulse err for one cycle and stay in IDLE.
  - MAC_OUT_SEL, MAC_ACC_SAT and MAC_TC are held stable for the whole job until the next accepted start.
- RUN:
  - s_ready=1.
  - On s_valid&s_ready, at the next cycle:
    - MAC_OPER_DATA=s_oper, MAC_COEF_DATA=s_coef, EFPGA_MATHB_CLK_EN=1.
    - If first: MAC_ACC_CLEAR=!cfg_rnd and MAC_ACC_RND=cfg_rnd (registered at job start); then clear first.
    - Otherwise CLEAR=RND=0.
  - With no handshake, EFPGA_MATHB_CLK_EN=0, CLEAR=RND=0, and the data outputs hold their values. Gaps of any length are legal.
  - When a pair is accepted with remaining==0, go to FLUSH and drop s_ready in the same edge. Otherwise decrement remaining.
- FLUSH:
  - EFPGA_MATHB_CLK_EN=1 for the last pair, which the MAC accumulates at the end of this cycle.
  - Next state is CAPT.
- CAPT:
  - All MAC controls are 0.
  - MAC_OUT is valid this cycle. The accumulator is final and the MAC's registered out_sel has been stable since at least the second cycle of the job.
  - Latch r_data=MAC_OUT, set r_valid=1, go to RESULT.
- Latency: the edge that accepts the last pair, plus 2 edges, gives r_valid=1.
- RESULT:
  - r_data and r_valid are held until r_ready=1.
  - On r_ready=1, clear r_valid and go to IDLE.
  - start in that same cycle is ignored; a new job is accepted only from IDLE.
- abort=1 in RUN, FLUSH, CAPT or RESULT:
  - Go to IDLE next edge with s_ready=0, r_valid=0 and EFPGA_MATHB_CLK_EN=0.
  - abort wins over a simultaneous handshake: the pair is not accepted.
  - abort in IDLE has no effect.
- start while busy is ignored and does not pulse err.
- Arithmetic (rounding, saturation, bit select) is performed entirely by the MAC; the feeder only sequences it.
- Single-pair job (cfg_len=0): the pair is both first and last; CLEAR or RND is asserted together with EFPGA_MATHB_CLK_EN.
- Reset mid-job: immediate return to IDLE, all outputs 0. The MAC accumulator is not guaranteed cleared, but the next job's first-pair CLEAR or RND makes it correct.

Test Plan:
- Unsigned accumulate: tc=0, sat=0, rnd=0, out_sel=0, len=2, pairs (2,3),(4,5),(1,1) → r_data=0x1B; CLEAR=1 only on the first CLK_EN cycle.
- Signed accumulate: tc=1, len=1, pairs (0xFD,0x04),(0x02,0x02) → r_data=0xF8 (-8).
- Saturation: tc=1, sat=1, out_sel=0, len=0, pair (0x7F,0x7F) → r_data=0x7F. Same job with sat=0 → r_data=0x01.
- Rounding: rnd=1, out_sel=4, len=0, pair (3,5) → r_data=0x01 (RND=1, CLEAR=0 on the CLK_EN cycle). Same job with rnd=0 → 0x00.
- Backpressure and gaps: s_valid low for 3 cycles between pairs, r_ready held low for 5 cycles → CLK_EN=0 during gaps, r_data and r_valid stable, same result as with no gaps.
- Error and abort paths:
  - start with out_sel=17 → err pulse, busy stays 0.
  - abort in RUN after 1 of 3 pairs → IDLE, no r_valid.
  - acc_ff_rst mid-RUN → all outputs 0, next job returns the correct value.
